// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants, result type and popcount for the add result buffer
package add_pkg;

  localparam int ADD_WIDTH   = 16;
  localparam int ADD_LATENCY = 4;

  typedef logic [ADD_WIDTH:0] add_result_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/add_result_buffer_if.sv
// rtl/add_result_buffer_if.sv - issue/result handshake bundle; stats signals exist only with ADD_RESULT_STATS_EN
interface add_result_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic [CW-1:0]    count;
  logic             overflow;
`ifdef ADD_RESULT_STATS_EN
  logic [31:0]      issued_cnt;
  logic [31:0]      retired_cnt;

  modport master (
    output issue_valid, S, Cout, out_ready,
    input  issue_ready, out_valid, out_data, count, overflow, issued_cnt, retired_cnt
  );
  modport slave (
    input  issue_valid, S, Cout, out_ready,
    output issue_ready, out_valid, out_data, count, overflow, issued_cnt, retired_cnt
  );
`else
  modport master (
    output issue_valid, S, Cout, out_ready,
    input  issue_ready, out_valid, out_data, count, overflow
  );
  modport slave (
    input  issue_valid, S, Cout, out_ready,
    output issue_ready, out_valid, out_data, count, overflow
  );
`endif
endinterface

// File: rtl/add_result_fifo.sv
// rtl/add_result_fifo.sv - single-clock result FIFO with occupancy count, no read bypass
module add_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/add_result_buffer.sv
// rtl/add_result_buffer.sv - tracks valid adder issue slots, queues results, grants issue credit
// Optional issue/retire counters enabled by ADD_RESULT_STATS_EN.
module add_result_buffer
  import add_pkg::*;
#(
  parameter int WIDTH   = ADD_WIDTH,
  parameter int LATENCY = ADD_LATENCY,
  parameter int DEPTH   = 8
) (
  input logic               clk,
  input logic               rst_n,
  add_result_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0] vld;
  logic               accept;
  logic               push;
  logic               pop;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WIDTH:0]     head_data;
  logic [31:0]        outstanding;
  logic               overflow_q;

  assign accept = bus.issue_valid && bus.issue_ready;
  assign push   = vld[LATENCY-1];
  assign pop    = bus.out_ready && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld <= (vld << 1) | LATENCY'(accept);
    end
  end

  // Credit counts both queued results and those still inside the adder.
  assign outstanding     = 32'(fifo_count) + popcount(32'(vld));
  assign bus.issue_ready = (outstanding < 32'(DEPTH));

  add_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.Cout, bus.S}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_data;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;

`ifdef ADD_RESULT_STATS_EN
  logic [31:0] issued_q;
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      if (accept) issued_q  <= issued_q + 1'b1;
      if (pop)    retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.issued_cnt  = issued_q;
  assign bus.retired_cnt = retired_q;
`endif

endmodule

// File: doc/add_result_buffer.md
Name: add_result_buffer

Overview:
- Sits directly downstream of the pipelined staggered adder (stagerred_add).
- Tracks which issue slots carry real operands through the adder's fixed latency.
- Captures each valid {Cout,S} result into a small FIFO and presents it on a valid/ready output.
- Adder has no stall input, so this block gives the upstream operand issuer credit-based flow control (issue_ready). A result never arrives at a full FIFO.

Parameters:
- WIDTH, 16: adder operand width; result is WIDTH+1 bits.
- LATENCY, 4: cycles from operand issue (posedge k) to result valid on S/Cout (sampled at posedge k+LATENCY); must be >= 1.
- DEPTH, 8: result FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  upstream drives real operands into the adder this cycle.
- issue_ready  out  1  upstream may issue; issue accepted when issue_valid && issue_ready.
- S  in  WIDTH  adder sum output.
- Cout  in  1  adder carry output.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head; pop when out_valid && out_ready.
- out_data  out  WIDTH+1  {Cout,S} of head entry.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid shift register vld[LATENCY-1:0] cleared; FIFO pointers and count = 0.
  - out_valid = 0, out_data = 0, overflow = 0, issue_ready = 1.
- Issue slots: an issue_valid cycle with issue_ready=0 is not accepted. It is not tracked, and its adder result is ignored.
- Tracking: each posedge, vld shifts by one; vld[0] <= accepted issue.
- Capture: when vld[LATENCY-1]=1 at a posedge, {Cout,S} is pushed. Latency from accept to push = LATENCY cycles.
- Visibility: out_valid rises the cycle after the push (registered FIFO, no bypass). Minimum accept-to-out_valid = LATENCY+1 edges.
- Credit: issue_ready = (count + popcount(vld)) < DEPTH, computed combinationally from registered state only. It has no combinational path from issue_valid or out_ready.
- Pop the same cycle as push: both occur, count unchanged. Allowed when full.
- Push when count==DEPTH and no pop (only possible on credit violation): data dropped, overflow set, cleared only by reset.
- Pop when empty: ignored, no pointer movement.
- Pointers are log2(DEPTH) bits and wrap naturally; count is separate and saturates at no point (range 0..DEPTH).
- out_data holds the head entry and is stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight tracking is discarded. Adder results emerging after reset deassertion are ignored since vld=0.

Optional Feature:
- Macro: ADD_RESULT_STATS_EN.
- When defined:
  - Extra outputs issued_cnt[31:0] (accepted issues) and retired_cnt[31:0] (pops).
  - Both counters wrap modulo 2^32 and reset to 0.
  - Invariant: issued_cnt - retired_cnt == count + popcount(vld).
- When undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package add_pkg:
  - ADD_WIDTH=16 and ADD_LATENCY=4 constants.
  - Typedef add_result_t = logic [ADD_WIDTH:0].
  - Function popcount over the valid vector.
- Sub-module add_result_fifo (DEPTH, DW): synchronous single-clock FIFO with push, pop, count, full, empty; instantiated once.
- Tracking shift register and credit logic live in the top.

Test Plan:
- After reset with no issues: issue_ready=1, out_valid=0, count=0, overflow=0.
- Issue A=16'h0001, B=16'hFFFF, Cin=0 at edge k: push at k+4, out_valid at k+5, out_data=17'h10000. Then pop, count returns to 0.
- out_ready=0, issue every cycle: exactly 8 accepted. issue_ready falls when count+in-flight reaches 8, count settles at 8. overflow stays 0, no result lost on later drain.
- Full FIFO with simultaneous push and pop each cycle: count stays 8. Results emerge in issue order across pointer wrap (≥20 transactions with random A/B/Cin match A+B+Cin).
- Force push with count=8 (drive issue_valid ignoring issue_ready is insufficient, so bench backdoor-forces vld[3]=1): overflow=1, sticky until rst_n pulse.
- Assert rst_n low with 3 results in flight and 2 queued: outputs go to reset values immediately. After release, nothing appears on out_valid. With ADD_RESULT_STATS_EN, counters read 0.
